// File: rtl/ysyx_24100006_pipe_buf_if.sv
// Handshake bundle for the inter-stage pipeline buffer: upstream push side,
// downstream pop side, flush and occupancy.
interface ysyx_24100006_pipe_buf_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output flush_i, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count_o
  );

  modport slave (
    input  flush_i, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count_o
  );
endinterface

// File: rtl/ysyx_24100006_pipe_buf.sv
// DEPTH-entry circular FIFO between two pipeline stages, valid/ready on both sides.
// Define PIPE_BUF_BYPASS_EN to give an empty buffer a zero-latency in->out path.
module ysyx_24100006_pipe_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ysyx_24100006_pipe_buf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              bypass;
  logic              out_valid;
  logic              push;
  logic              pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef PIPE_BUF_BYPASS_EN
  assign bypass = empty & bus.in_valid & ~bus.flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A full buffer still accepts when the head leaves in the same cycle.
  assign bus.in_ready  = ~bus.flush_i & (~full | bus.out_ready);
  assign out_valid     = ~bus.flush_i & (~empty | bypass);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = bypass ? bus.in_data : (out_valid ? mem[rd_ptr] : '0);
  assign bus.count_o   = count;

  // A bypassed item taken downstream never touches storage.
  assign push = bus.in_valid & bus.in_ready & ~(bypass & bus.out_ready);
  assign pop  = out_valid & bus.out_ready & ~bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
